// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: word/block types, round count, rotate and P1.
// Used by the message expansion stage and by the compression function.
package sm3_pkg;

    // Bit 0 is the most significant bit of a word / of W_0 in a block.
    typedef logic [0:31]  word_t;
    typedef logic [0:511] block_t;

    localparam int SM3_ROUNDS = 64;

    // Expansion stage control states.
    typedef enum logic {
        IDLE,
        RUN
    } expand_state_e;

    // 32-bit rotate left; bit 0 is the MSB, so << moves towards bit 0.
    function automatic word_t rotl32(word_t x, int unsigned n);
        int unsigned s;
        s = n % 32;
        if (s == 0) begin
            return x;
        end
        return (x << s) | (x >> (32 - s));
    endfunction

    // SM3 permutation used in message expansion.
    function automatic word_t p1(word_t x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expand_word.sv
// Combinational SM3 expansion step: produces W_{j+16} from the window taps
// W_j, W_{j+3}, W_{j+7}, W_{j+10} and W_{j+13}.
module sm3_expand_word
    import sm3_pkg::*;
(
    input  word_t win0_i,
    input  word_t win3_i,
    input  word_t win7_i,
    input  word_t win10_i,
    input  word_t win13_i,
    output word_t w16_o
);

    // W_{j+16} = P1(W_j ^ W_{j+7} ^ (W_{j+13} <<< 15)) ^ (W_{j+3} <<< 7) ^ W_{j+10}
    assign w16_o = p1(win0_i ^ win7_i ^ rotl32(win13_i, 15))
                 ^ rotl32(win3_i, 7) ^ win10_i;

endmodule

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: accepts one 512-bit padded block and streams the 64
// (W_j, W'_j) pairs using a 16-word sliding window.
// Optional macro SM3_EXPAND_BACKPRESSURE_EN: when defined, out_ready stalls
// the stream; when undefined, every RUN cycle is a transfer.
module sm3_msg_expand
    import sm3_pkg::*;
#(
    parameter int ROUNDS = SM3_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:511] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:31]  w_j,
    output logic [0:31]  wp_j,
    output logic [0:5]   round,
    output logic         last
);

    localparam logic [0:5] LAST_ROUND = 6'(ROUNDS - 1);

    expand_state_e state_q;
    logic [0:5]    cnt_q;
    word_t         win_q [16];
    word_t         w16_d;
    logic          xfer;

`ifdef SM3_EXPAND_BACKPRESSURE_EN
    assign xfer = (state_q == RUN) && out_ready;
`else
    // The port is kept so instantiations are identical in both builds.
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign xfer = (state_q == RUN);
`endif

    sm3_expand_word u_expand_word (
        .win0_i  (win_q[0]),
        .win3_i  (win_q[3]),
        .win7_i  (win_q[7]),
        .win10_i (win_q[10]),
        .win13_i (win_q[13]),
        .w16_o   (w16_d)
    );

    // FSM, round counter and sliding window: load on accept, shift on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the window is a small flop array, not a RAM, and must read
            // as zero after reset so w_j/wp_j come up cleared; resetting it is
            // intentional here.
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            // NOTE: every assignment in this block is non-blocking so the shift
            // below reads the pre-edge window for all sixteen words.
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) begin
                            win_q[k] <= block_in[32*k +: 32];
                        end
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        for (int k = 0; k < 15; k++) begin
                            win_q[k] <= win_q[k+1];
                        end
                        win_q[15] <= w16_d;
                        cnt_q     <= cnt_q + 6'd1;
                        if (cnt_q == LAST_ROUND) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers, plus one XOR level for W'_j.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign w_j       = win_q[0];
    assign wp_j      = win_q[0] ^ win_q[4];
    assign round     = cnt_q;
    assign last      = (state_q == RUN) && (cnt_q == LAST_ROUND);

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand against an array-based SM3 model.
module tb_sm3_msg_expand;

`ifdef SM3_EXPAND_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:511] block_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:31]  w_j;
    logic [0:31]  wp_j;
    logic [0:5]   round;
    logic         last;

    sm3_msg_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_j       (w_j),
        .wp_j      (wp_j),
        .round     (round),
        .last      (last)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] msg    [16];
    logic [31:0] ref_w  [68];
    logic [31:0] ref_wp [64];
    logic [31:0] obs_w  [64];
    logic [31:0] obs_wp [64];

    function automatic logic [31:0] t_rotl(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] t_p1(logic [31:0] x);
        return x ^ t_rotl(x, 15) ^ t_rotl(x, 23);
    endfunction

    // Full SM3 expansion of msg into W_0..W_67 and W'_0..W'_63.
    function automatic void build_ref();
        for (int j = 0; j < 16; j++) ref_w[j] = msg[j];
        for (int j = 16; j < 68; j++)
            ref_w[j] = t_p1(ref_w[j-16] ^ ref_w[j-9] ^ t_rotl(ref_w[j-3], 15))
                     ^ t_rotl(ref_w[j-13], 7) ^ ref_w[j-6];
        for (int j = 0; j < 64; j++) ref_wp[j] = ref_w[j] ^ ref_w[j+4];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_block();
        for (int i = 0; i < 16; i++) block_in[32*i +: 32] = msg[i];
    endtask

    // Called just after a negedge; offers the block and waits for acceptance.
    task automatic accept(input bit hold, output int t);
        int n;
        pack_block();
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        t = cyc;
        @(posedge clk);
        #1 in_valid = hold;
    endtask

    // Follows the stream for rounds 0..stop-1; mode 0 = ready high,
    // 1 = random ready, 2 = ready low throughout.
    task automatic trace(input int stop, input int mode, output int iters);
        int j;
        j = 0;
        iters = 0;
        while (j < stop) begin
            @(negedge clk);
            iters++;
            if (iters > 2000) begin
                check("trace_timeout", 64'(j), 64'(stop));
                return;
            end
            check($sformatf("out_valid[%0d]", j), 64'(out_valid), 64'd1);
            check($sformatf("in_ready[%0d]", j), 64'(in_ready), 64'd0);
            check($sformatf("round[%0d]", j), 64'(round), 64'(j));
            check($sformatf("w_j[%0d]", j), 64'(w_j), 64'(ref_w[j]));
            check($sformatf("wp_j[%0d]", j), 64'(wp_j), 64'(ref_wp[j]));
            check($sformatf("last[%0d]", j), 64'(last), 64'(j == 63));
            obs_w[j]  = w_j;
            obs_wp[j] = wp_j;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (!BP || out_ready) j++;
        end
        if (stop == 64) begin
            @(negedge clk);
            check("in_ready_after_last", 64'(in_ready), 64'd1);
            check("out_valid_after_last", 64'(out_valid), 64'd0);
            check("last_after_last", 64'(last), 64'd0);
        end
    endtask

    initial begin
        int t0, t1, it;

        // Reset state.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_w_j", 64'(w_j), 64'd0);
        check("rst_wp_j", 64'(wp_j), 64'd0);

        // "abc" block, against published words too.
        foreach (msg[i]) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_ref();
        accept(1'b0, t0);
        trace(64, 0, it);
        check("abc_w0", 64'(obs_w[0]), 64'h61626380);
        check("abc_wp0", 64'(obs_wp[0]), 64'h61626380);
        check("abc_w16", 64'(obs_w[16]), 64'h9092e200);
        check("abc_w18", 64'(obs_w[18]), 64'h000c0606);

        // "abcd" x16 first block.
        foreach (msg[i]) msg[i] = 32'h61626364;
        build_ref();
        accept(1'b0, t0);
        trace(64, 0, it);

        // Random block with random out_ready.
        foreach (msg[i]) msg[i] = $urandom;
        build_ref();
        accept(1'b0, t0);
        trace(64, 1, it);

        // Back-to-back blocks with in_valid held high.
        foreach (msg[i]) msg[i] = $urandom;
        build_ref();
        accept(1'b1, t0);
        foreach (msg[i]) msg[i] = $urandom;
        pack_block();
        begin
            logic [31:0] ref_save [68];
            ref_save = ref_w;
            build_ref();
            ref_w = ref_save;
            for (int j = 0; j < 64; j++) ref_wp[j] = ref_w[j] ^ ref_w[j+4];
        end
        trace(64, 0, it);
        build_ref();
        accept(1'b0, t1);
        check("b2b_period", 64'(t1 - t0), 64'd65);
        trace(64, 0, it);

        // Asynchronous reset in the middle of a block.
        foreach (msg[i]) msg[i] = $urandom;
        build_ref();
        accept(1'b0, t0);
        trace(30, 0, it);
        @(negedge clk);
        check("mid_round30", 64'(round), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_round", 64'(round), 64'd0);
        check("mid_rst_w_j", 64'(w_j), 64'd0);
        check("mid_rst_wp_j", 64'(wp_j), 64'd0);
        check("mid_rst_last", 64'(last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        foreach (msg[i]) msg[i] = $urandom;
        build_ref();
        accept(1'b0, t0);
        trace(64, 0, it);

`ifndef SM3_EXPAND_BACKPRESSURE_EN
        // out_ready ignored: 64 pairs in 64 cycles with it held low.
        foreach (msg[i]) msg[i] = $urandom;
        build_ref();
        accept(1'b0, t0);
        trace(64, 2, it);
        check("no_bp_cycles", 64'(it), 64'd64);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm3_msg_expand.md
# sm3_msg_expand

Message-expansion stage of the SM3 hash pipeline. Sits between the padded-block assembler and the compression function. Accepts one 512-bit padded message block and streams the 64 round word pairs (W_j, W'_j), one pair per round, to the compression rounds. Uses a 16-word sliding window instead of storing all 132 expanded words.

## Interface
Parameters:
- ROUNDS, 64, number of (W_j, W'_j) pairs emitted per block; fixed by SM3, not overridable in practice.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  block_in is valid this cycle.
- in_ready  output  1  idle and able to accept a block.
- block_in  input  [0:511]  padded block; bit 0 is the MSB of W_0; W_i = block_in[32i +: 32], big-endian.
- out_valid  output  1  w_j / wp_j / round are valid.
- out_ready  input  1  downstream accepts the current pair.
- w_j  output  [0:31]  W_j.
- wp_j  output  [0:31]  W'_j = W_j ^ W_{j+4}.
- round  output  [0:5]  index j of the current pair.
- last  output  1  high together with out_valid when round == 63.

## Operation
- States: IDLE, RUN.
- IDLE: in_ready=1, out_valid=0. When in_valid && in_ready, load the window win[0..15] = W_0..W_15, clear the round counter, and go to RUN.
- RUN: in_ready=0, out_valid=1. Outputs are w_j=win[0], wp_j=win[0]^win[4], round=counter.
- Transfer: a transfer occurs when out_valid && out_ready. On each transfer:
  - shift the window down one word: win[k] <= win[k+1];
  - win[15] <= P1(win[0]^win[7]^rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10];
  - counter += 1.
- Functions: P1(x)=x^rotl(x,15)^rotl(x,23). All arithmetic is 32-bit XOR/rotate only; no carries.
- Exit: a transfer with counter==63 returns the block to IDLE. The window contents are don't-care afterwards. W_64..W_67 are never emitted.
- No transfer: if out_ready=0, all outputs hold stable and the window and counter do not change.
- in_valid during RUN: ignored, because in_ready=0. The upstream holds the block.
- Reset values (rst_n low, any time, including mid-block): state=IDLE, in_ready=1, out_valid=0, last=0, round=0, w_j=0, wp_j=0, window cleared. The partial block is discarded, and downstream sees no further valid pairs.

## Timing
- Acceptance edge to first out_valid: 1 cycle. The pair for round 0 is visible in the cycle after the handshake.
- One round per cycle with out_ready held high. The block occupies 64 RUN cycles.
- in_ready rises in the cycle after the round-63 transfer.
- Back-to-back block period: 65 cycles (64 RUN + 1 IDLE acceptance).
- Outputs are registers or a single XOR level from the window. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- SM3_EXPAND_BACKPRESSURE_EN defined: out_ready is honoured as described above.
- SM3_EXPAND_BACKPRESSURE_EN undefined:
  - out_ready is ignored and treated as 1; every RUN cycle is a transfer.
  - The port stays in the port list so instantiations do not change.

## Structure
- Shared package sm3_pkg holds:
  - typedef word_t ([0:31]) and block_t ([0:511]);
  - the constant SM3_ROUNDS=64;
  - functions rotl32 and p1.
  
  The compression function reuses these (it also needs P0 and rotl).
- One sub-module, sm3_expand_word: combinational; takes win[0], win[3], win[7], win[10], win[13] and produces W_{j+16}. It is unit-testable in isolation.
- The top level contains the FSM, the counter, and the window register.

## Test plan
- Reset then "abc" block (61626380, 00000000 x14, 00000018) -> round 0: w_j=61626380, wp_j=61626380; round 16: w_j=9092e200; round 18: w_j=000c0606; last at round 63; in_ready high one cycle later.
- Full 64-round trace for "abc" and a 64-byte "abcd"x16 first block, compared against a software SM3 model -> all 64 (W_j, W'_j) pairs match.
- out_ready toggled pseudo-randomly (BACKPRESSURE_EN defined) -> outputs stable while stalled; sequence identical to the unstalled run; no pair duplicated or dropped.
- Two blocks offered back to back with in_valid held high -> second accepted exactly 65 cycles after the first; no overlap of rounds.
- rst_n asserted at round 30 -> out_valid=0 asynchronously; after release, in_ready=1 and a new block starts at round 0 with correct words.
- Build without the macro, out_ready=0 throughout -> rounds still advance every cycle; the 64 pairs complete in 64 cycles.
